// File: rtl/instruction_memory_loader_if.sv
// Byte-stream loader bus: host byte link in, instruction-memory byte write port and
// core/status lines out. The loader uses the slave modport.
interface instruction_memory_loader_if #(
   parameter int unsigned ADDR_WIDTH = 64
);
   logic                  Load_Start;
   logic [7:0]            Byte_In;
   logic                  Byte_Valid;
   logic                  Byte_Ready;
   logic                  Mem_Write_Enable;
   logic [ADDR_WIDTH-1:0] Mem_Address;
   logic [7:0]            Mem_Write_Data;
   logic                  Core_Hold;
   logic                  Load_Done;
   logic                  Load_Error;

   modport master (
      output Load_Start, Byte_In, Byte_Valid,
      input  Byte_Ready, Mem_Write_Enable, Mem_Address, Mem_Write_Data,
             Core_Hold, Load_Done, Load_Error
   );

   modport slave (
      input  Load_Start, Byte_In, Byte_Valid,
      output Byte_Ready, Mem_Write_Enable, Mem_Address, Mem_Write_Data,
             Core_Hold, Load_Done, Load_Error
   );
endinterface

// File: rtl/instruction_memory_loader.sv
// Streams a length-prefixed program into byte-wide instruction memory, little-endian, holding the core.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module instruction_memory_loader #(
   parameter int unsigned MEM_BYTES    = 256,
   parameter int unsigned ADDR_WIDTH   = 64,
   parameter int unsigned BASE_ADDRESS = 0
) (
   input logic                   clk,
   input logic                   reset,
   instruction_memory_loader_if.slave bus
);
`ifdef LOADER_CHECKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif
   localparam logic [17:0]           CAP  = 18'(MEM_BYTES - BASE_ADDRESS);
   localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDRESS);

   typedef enum logic [2:0] {
      S_IDLE, S_COUNT_LO, S_COUNT_HI, S_DATA, S_CHECK, S_DONE
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [7:0]            r_cnt_lo;
   logic [17:0]           r_bcnt;
   logic [7:0]            r_csum;
   logic [ADDR_WIDTH-1:0] r_ptr;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [7:0]            r_wdata;
   logic                  r_we, r_hold, r_done, r_err;
   logic                  w_ready, w_xfer;
   logic [15:0]           w_n;
   logic [17:0]           w_total;

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = (r_state == S_COUNT_LO) || (r_state == S_COUNT_HI) ||
                    (r_state == S_DATA)     || (r_state == S_CHECK);
      w_xfer      = w_ready && bus.Byte_Valid;
      w_n         = {bus.Byte_In, r_cnt_lo};
      w_total     = {w_n, 2'b00};
      case (r_state)
         S_IDLE, S_DONE: if (bus.Load_Start) w_state_nxt = S_COUNT_LO;
         S_COUNT_LO:     if (w_xfer) w_state_nxt = S_COUNT_HI;
         S_COUNT_HI: begin
            if (w_xfer) begin
               if (w_n == 16'd0)     w_state_nxt = CHK_EN ? S_CHECK : S_DONE;
               else if (w_total > CAP) w_state_nxt = S_DONE;
               else                    w_state_nxt = S_DATA;
            end
         end
         S_DATA:  if (w_xfer && r_bcnt == 18'd1) w_state_nxt = CHK_EN ? S_CHECK : S_DONE;
         S_CHECK: if (w_xfer) w_state_nxt = S_DONE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_cnt_lo <= '0;
         r_bcnt   <= '0;
         r_csum   <= '0;
         r_ptr    <= BASE;
         r_addr   <= BASE;
         r_wdata  <= '0;
         r_we     <= 1'b0;
         r_hold   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_we    <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (bus.Load_Start) begin
                  r_hold <= 1'b1;
                  r_done <= 1'b0;
                  r_err  <= 1'b0;
                  r_csum <= '0;
               end
            end
            S_COUNT_LO: if (w_xfer) r_cnt_lo <= bus.Byte_In;
            S_COUNT_HI: begin
               if (w_xfer) begin
                  if (w_n == 16'd0) begin
                     if (!CHK_EN) begin
                        r_done <= 1'b1;
                        r_hold <= 1'b0;
                     end
                  end else if (w_total > CAP) begin
                     // Oversized program: fail without writing, keep the core held
                     r_done <= 1'b1;
                     r_err  <= 1'b1;
                  end else begin
                     r_bcnt <= w_total;
                     r_ptr  <= BASE;
                  end
               end
            end
            S_DATA: begin
               if (w_xfer) begin
                  r_we    <= 1'b1;
                  r_wdata <= bus.Byte_In;
                  r_addr  <= r_ptr;
                  r_ptr   <= r_ptr + ADDR_WIDTH'(1);
                  r_bcnt  <= r_bcnt - 18'd1;
                  r_csum  <= r_csum ^ bus.Byte_In;
                  if (r_bcnt == 18'd1 && !CHK_EN) begin
                     r_done <= 1'b1;
                     r_hold <= 1'b0;
                  end
               end
            end
            S_CHECK: begin
               if (w_xfer) begin
                  r_done <= 1'b1;
                  if (bus.Byte_In != r_csum) r_err  <= 1'b1;
                  else                       r_hold <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.Byte_Ready       = w_ready;
   assign bus.Mem_Write_Enable = r_we;
   assign bus.Mem_Address      = r_addr;
   assign bus.Mem_Write_Data   = r_wdata;
   assign bus.Core_Hold        = r_hold;
   assign bus.Load_Done        = r_done;
   assign bus.Load_Error       = r_err;
endmodule

// File: tb/tb_instruction_memory_loader.sv
// Randomized bench for instruction_memory_loader: sessions scored against a byte-stream reference model.
module tb_instruction_memory_loader;
   localparam int unsigned MEMB = 256;
   localparam int unsigned AW   = 64;
   localparam int unsigned BASE = 0;
   localparam int unsigned CAP  = MEMB - BASE;
`ifdef LOADER_CHECKSUM_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_total = 0;
   int   n_bad = 0;

   logic [63:0] wa_q[$];
   logic [7:0]  wd_q[$];
   logic [7:0]  dat[$];
   logic [7:0]  tx[$];
   int          nd;
   bit          exp_err;

   instruction_memory_loader_if #(.ADDR_WIDTH(AW)) bus();

   instruction_memory_loader #(
      .MEM_BYTES(MEMB), .ADDR_WIDTH(AW), .BASE_ADDRESS(BASE)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Every strobe-cycle is logged; duplicates or gaps show up against the model.
   always @(negedge clk) begin
      if (bus.Mem_Write_Enable) begin
         wa_q.push_back(bus.Mem_Address);
         wd_q.push_back(bus.Mem_Write_Data);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: what the session stream looks like and what it must produce.
   task automatic prep(input int n, input bit bad_sum);
      logic [7:0] cs;
      bit ovf;
      ovf = (4 * n) > CAP;
      nd  = ovf ? 0 : 4 * n;
      while (dat.size() < nd) dat.push_back(8'($urandom));
      cs = 8'h00;
      tx = {};
      tx.push_back(n[7:0]);
      tx.push_back(n[15:8]);
      for (int i = 0; i < nd; i++) begin
         tx.push_back(dat[i]);
         cs = cs ^ dat[i];
      end
      if (CHK && !ovf) tx.push_back(bad_sum ? (cs ^ 8'h01) : cs);
      exp_err = ovf || (CHK && !ovf && bad_sum);
   endtask

   task automatic start_load();
      bus.Load_Start = 1'b1;
      bus.Byte_Valid = 1'($urandom_range(0, 1));
      bus.Byte_In    = 8'($urandom);
      @(posedge clk); #1;
      bus.Load_Start = 1'b0;
      bus.Byte_Valid = 1'b0;
      chk("hold_on", bus.Core_Hold, 1);
      chk("done_clr", bus.Load_Done, 0);
      chk("err_clr", bus.Load_Error, 0);
   endtask

   // mode 0: always valid, 1: alternate 1/0, 2: random gaps
   task automatic send(input int upto, input int ndata, input int mode);
      int idx;
      int cyc;
      bit v;
      bit alt;
      bit exp_we;
      idx = 0; cyc = 0; alt = 1'b1;
      while (idx < upto && cyc < 5000) begin
         case (mode)
            0:       v = 1'b1;
            1:       begin v = alt; alt = ~alt; end
            default: v = 1'($urandom_range(0, 1));
         endcase
         bus.Byte_Valid = v;
         bus.Byte_In    = v ? tx[idx] : 8'($urandom);
         bus.Load_Start = ($urandom_range(0, 7) == 0);
         chk("rdy", bus.Byte_Ready, 1);
         @(posedge clk); #1;
         exp_we = v && idx >= 2 && idx < 2 + ndata;
         chk("we", bus.Mem_Write_Enable, exp_we);
         if (exp_we) chk("wdata_now", bus.Mem_Write_Data, tx[idx]);
         if (v) idx++;
         cyc++;
      end
      bus.Byte_Valid = 1'b0;
      bus.Load_Start = 1'b0;
      if (idx < upto) chk("timeout", idx, upto);
   endtask

   task automatic check_writes(input int cnt);
      chk("nwr", wa_q.size(), cnt);
      for (int i = 0; i < cnt && i < wa_q.size(); i++) begin
         chk("waddr", wa_q[i], 64'(BASE + i));
         chk("wdata", wd_q[i], dat[i]);
      end
   endtask

   task automatic run(input int n, input int mode, input bit bad_sum);
      prep(n, bad_sum);
      wa_q = {}; wd_q = {};
      start_load();
      send(tx.size(), nd, mode);
      @(posedge clk); #1;
      chk("done", bus.Load_Done, 1);
      chk("err", bus.Load_Error, exp_err);
      chk("hold", bus.Core_Hold, exp_err);
      chk("rdy_idle", bus.Byte_Ready, 0);
      chk("we_idle", bus.Mem_Write_Enable, 0);
      check_writes(nd);
      dat = {};
   endtask

   task automatic check_reset_state();
      chk("rst_we", bus.Mem_Write_Enable, 0);
      chk("rst_addr", bus.Mem_Address, 64'(BASE));
      chk("rst_wdata", bus.Mem_Write_Data, 0);
      chk("rst_hold", bus.Core_Hold, 0);
      chk("rst_done", bus.Load_Done, 0);
      chk("rst_err", bus.Load_Error, 0);
      chk("rst_rdy", bus.Byte_Ready, 0);
   endtask

   initial begin
      bus.Load_Start = 1'b0;
      bus.Byte_Valid = 1'b0;
      bus.Byte_In    = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state();
      reset = 1'b1;
      @(posedge clk); #1;

      dat = {8'h93, 8'h02, 8'h00, 8'h10, 8'h13, 8'h03, 8'h70, 8'h00};
      run(2, 0, 1'b0);
      run(65, 0, 1'b0);
      run(0, 0, 1'b0);
      run(3, 1, 1'b0);
`ifdef LOADER_CHECKSUM_EN
      dat = {8'h13, 8'h00, 8'h00, 8'h00};
      run(1, 0, 1'b0);
      dat = {8'h13, 8'h00, 8'h00, 8'h00};
      run(1, 0, 1'b1);
`endif
      run(64, 2, 1'b0);

      // Abort after the third data byte, then restart from the base address
      prep(4, 1'b0);
      wa_q = {}; wd_q = {};
      start_load();
      send(5, nd, 0);
      reset = 1'b0;
      @(posedge clk); #1;
      check_reset_state();
      reset = 1'b1;
      check_writes(3);
      dat = {};
      run(2, 2, 1'b0);

      for (int k = 0; k < 15; k++) begin
         run($urandom_range(0, 70), $urandom_range(0, 2), CHK ? 1'($urandom_range(0, 1)) : 1'b0);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
